// File: rtl/smaesh_mc_pkg.sv
// smaesh_mc_pkg: shared types, constants and GF(2^8) helpers for the masked MixColumns engine
package smaesh_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    localparam int COL_W = 32;

    // Matrix row 0 coefficients, one nibble per column offset (offset 0 in the top nibble)
    localparam logic [15:0] FWD_COEF = 16'h2311;
    localparam logic [15:0] INV_COEF = 16'hEBD9;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant of at most 4 bits, built from repeated xtime
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
    endfunction

endpackage

// File: rtl/msk_aes_mc_col_dual.sv
// msk_aes_mc_col_dual: one unshared 32-bit column through MixColumns or InvMixColumns
module msk_aes_mc_col_dual
    import smaesh_mc_pkg::*;
(
    input  logic             inverse,
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    // Each output row is the row-0 coefficient vector rotated by the row index
    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int o = 0; o < 4; o++) begin
                col_o[8*r +: 8] = col_o[8*r +: 8] ^ gmul(col_i[8*((r+o)%4) +: 8],
                    inverse ? INV_COEF[4*(3-o) +: 4] : FWD_COEF[4*(3-o) +: 4]);
            end
        end
    end

endmodule

// File: rtl/msk_aes_mc_serial.sv
// msk_aes_mc_serial: masked column-serial (Inv)MixColumns; SMAESH_MC_BYPASS_EN adds a rotate-only bypass
module msk_aes_mc_serial
    import smaesh_mc_pkg::*;
#(
    parameter int d = 2,
    parameter int C = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_inverse,
    input  logic [128*d-1:0] in_data,
`ifdef SMAESH_MC_BYPASS_EN
    input  logic           in_bypass,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [128*d-1:0] out_data
);

    localparam int W  = 128 * d;
    localparam int SW = COL_W * d * C;
    localparam int CW = (C >= 4) ? 1 : $clog2(4 / C);
    localparam logic [CW-1:0] LAST = CW'(4 / C - 1);

    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_c
        $error("msk_aes_mc_serial: C must be 1, 2 or 4");
    end

    mc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  buf_q, buf_d;
    logic          inv_q, inv_d;
    logic [SW-1:0] mix_w, xf_w;
    logic [W-1:0]  rot_w;
    logic          accept;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = buf_q;

    // Split each low column into its shares, transform each share alone, and re-interleave
    for (genvar c = 0; c < C; c++) begin : g_col
        for (genvar s = 0; s < d; s++) begin : g_sh
            logic [COL_W-1:0] sh_i, sh_o;
            for (genvar b = 0; b < COL_W; b++) begin : g_bit
                assign sh_i[b] = buf_q[COL_W*d*c + 8*d*(b/8) + d*(b%8) + s];
                assign mix_w[COL_W*d*c + 8*d*(b/8) + d*(b%8) + s] = sh_o[b];
            end
            msk_aes_mc_col_dual u_col (
                .inverse (inv_q),
                .col_i   (sh_i),
                .col_o   (sh_o)
            );
        end
    end

`ifdef SMAESH_MC_BYPASS_EN
    logic byp_q, byp_d;
    assign xf_w = byp_q ? buf_q[SW-1:0] : mix_w;
`else
    assign xf_w = mix_w;
`endif

    // Transformed columns re-enter at the top so the state is back in order after 4/C steps
    if (C >= 4) begin : g_rot_full
        assign rot_w = xf_w;
    end else begin : g_rot_part
        assign rot_w = {xf_w, buf_q[W-1:SW]};
    end

    // Next-state logic: load on accept, rotate while busy, release on consumer handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        inv_d   = inv_q;
`ifdef SMAESH_MC_BYPASS_EN
        byp_d   = byp_q;
`endif
        if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            buf_d   = in_data;
            inv_d   = in_inverse;
`ifdef SMAESH_MC_BYPASS_EN
            byp_d   = in_bypass;
`endif
        end else if (state_q == BUSY) begin
            buf_d   = rot_w;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? DONE : BUSY;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            inv_q   <= inv_d;
        end
    end

`ifdef SMAESH_MC_BYPASS_EN
    // Bypass flag register, latched alongside the mode bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end
`endif

endmodule

// File: tb/tb_msk_aes_mc_serial.sv
// tb_msk_aes_mc_serial: three lanes (C=1,2,4, d=2) checked every cycle against a behavioural model
module tb_msk_aes_mc_serial;

    localparam logic [127:0] XS = 128'hc6c6c6c6_01010101_5c220af2_455313db;
    localparam logic [127:0] ES = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] BS = {96'h0, 32'hd5d4d4d4};
    localparam logic [127:0] BE = {96'h0, 32'hd6d7d5d5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit           have_job [3];
    int           job_t    [3];
    logic [255:0] job_exp  [3];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int t, input bit inv);
        if (inv) return (t == 0) ? 8'h0e : (t == 1) ? 8'h0b : (t == 2) ? 8'h0d : 8'h09;
        return (t == 0) ? 8'h02 : (t == 1) ? 8'h03 : 8'h01;
    endfunction

    function automatic logic [127:0] mc(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 4; r++)
                for (int t = 0; t < 4; t++)
                    o[8*(4*k+r) +: 8] = o[8*(4*k+r) +: 8] ^ gm(s[8*(4*k+(r+t)%4) +: 8], coef(t, inv));
        return o;
    endfunction

    function automatic logic [255:0] pack(input logic [127:0] s0, input logic [127:0] s1);
        logic [255:0] x;
        for (int b = 0; b < 16; b++)
            for (int j = 0; j < 8; j++) begin
                x[16*b+2*j]   = s0[8*b+j];
                x[16*b+2*j+1] = s1[8*b+j];
            end
        return x;
    endfunction

    function automatic logic [127:0] share(input logic [255:0] x, input int i);
        logic [127:0] s;
        for (int b = 0; b < 16; b++)
            for (int j = 0; j < 8; j++) s[8*b+j] = x[16*b+2*j+i];
        return s;
    endfunction

    function automatic logic [255:0] model(input logic [255:0] x, input bit inv, input bit byp);
        if (byp) return x;
        return pack(mc(share(x, 0), inv), mc(share(x, 1), inv));
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int CC = 1 << g;
        localparam int L  = 4 / CC;
        logic rst_n, in_valid, in_ready, in_inverse, in_bypass, out_valid, out_ready;
        logic [255:0] in_data, out_data;
        bit done, to;

        msk_aes_mc_serial #(.d(2), .C(CC)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_inverse (in_inverse),
            .in_data    (in_data),
`ifdef SMAESH_MC_BYPASS_EN
            .in_bypass  (in_bypass),
`endif
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data)
        );

        task automatic send(input logic [255:0] dat, input bit inv, input bit byp, input bit rnd_or);
            bit acc, ok;
            in_data = dat;
            in_inverse = inv;
            in_bypass = byp;
            in_valid = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                ok = acc;
                if (!ok && rnd_or) out_ready = ($urandom_range(3) != 0);
            end
            in_valid = 1'b0;
            if (!ok) to = 1'b1;
            if (rnd_or) out_ready = ($urandom_range(3) != 0);
        endtask

        initial begin
            logic [127:0] r;
            logic [255:0] v;
            rst_n = 1'b0; in_valid = 1'b0; in_inverse = 1'b0; in_bypass = 1'b0;
            in_data = '0; out_ready = 1'b1; done = 1'b0; to = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
            v = rnd256();
            r = v[127:0];
            if (g == 0) send(pack(r, XS ^ r), 1'b0, 1'b0, 1'b0);
            else        send(pack(r, ES ^ r), 1'b1, 1'b0, 1'b0);
            out_ready = 1'b0;
            repeat (L + 5) @(posedge clk);
            #1 out_ready = 1'b1;
            send(rnd256(), 1'($urandom_range(1)), 1'b0, 1'b0);
            repeat (L + 2) @(posedge clk);
            #1;
            if (g == 0) begin
                send(rnd256(), 1'b0, 1'b0, 1'b0);
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (6) @(posedge clk);
                #1;
            end
`ifdef SMAESH_MC_BYPASS_EN
            v = rnd256();
            r = v[127:0];
            send(pack(r, BS ^ r), 1'b0, 1'b1, 1'b0);
            send(pack(r, BS ^ r), 1'b0, 1'b0, 1'b0);
`endif
            for (int k = 0; k < 80; k++) begin
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3) != 0);
                end
                send(rnd256(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
            end
            out_ready = 1'b1;
            repeat (L + 3) @(posedge clk);
            #1 done = 1'b1;
        end
    end

    task automatic lane(input int l, input bit rst, input bit iv, input bit inv, input bit byp,
                        input bit ir, input bit ov, input bit ordy,
                        input logic [255:0] id, input logic [255:0] od);
        int  lat;
        bit  eov, eir, b;
        lat = 4 >> l;
        if (!rst) begin
            chk($sformatf("lane%0d reset out_valid", l), 256'(ov), 256'(0));
            chk($sformatf("lane%0d reset in_ready", l), 256'(ir), 256'(1));
            chk($sformatf("lane%0d reset out_data", l), od, '0);
            have_job[l] = 1'b0;
            return;
        end
        eov = have_job[l] && (cyc - job_t[l] >= lat);
        eir = !have_job[l] || (eov && ordy);
        chk($sformatf("lane%0d out_valid", l), 256'(ov), 256'(eov));
        chk($sformatf("lane%0d in_ready", l), 256'(ir), 256'(eir));
        if (eov) chk($sformatf("lane%0d out_data", l), od, job_exp[l]);
        if (eov && ordy) have_job[l] = 1'b0;
        if (iv && eir) begin
            b = 1'b0;
`ifdef SMAESH_MC_BYPASS_EN
            b = byp;
`endif
            have_job[l] = 1'b1;
            job_t[l] = cyc + 1;
            job_exp[l] = model(id, inv, b);
        end
    endtask

    initial begin
        logic [255:0] v;
        logic [127:0] rr;
        v = rnd256();
        rr = v[127:0];
        chk("pin mc fwd", 256'(mc(XS, 1'b0)), 256'(ES));
        chk("pin mc inv", 256'(mc(ES, 1'b1)), 256'(XS));
        chk("pin mc d4d4d4d5", 256'(mc(BS, 1'b0)), 256'(BE));
        chk("pin masked unmask", 256'(share(model(pack(rr, XS ^ rr), 1'b0, 1'b0), 0)
                                      ^ share(model(pack(rr, XS ^ rr), 1'b0, 1'b0), 1)), 256'(ES));
        chk("pin bypass", model(pack(rr, BS ^ rr), 1'b0, 1'b1), pack(rr, BS ^ rr));
        for (int l = 0; l < 3; l++) have_job[l] = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            lane(0, g_lane[0].rst_n, g_lane[0].in_valid, g_lane[0].in_inverse, g_lane[0].in_bypass,
                 g_lane[0].in_ready, g_lane[0].out_valid, g_lane[0].out_ready,
                 g_lane[0].in_data, g_lane[0].out_data);
            lane(1, g_lane[1].rst_n, g_lane[1].in_valid, g_lane[1].in_inverse, g_lane[1].in_bypass,
                 g_lane[1].in_ready, g_lane[1].out_valid, g_lane[1].out_ready,
                 g_lane[1].in_data, g_lane[1].out_data);
            lane(2, g_lane[2].rst_n, g_lane[2].in_valid, g_lane[2].in_inverse, g_lane[2].in_bypass,
                 g_lane[2].in_ready, g_lane[2].out_valid, g_lane[2].out_ready,
                 g_lane[2].in_data, g_lane[2].out_data);
            if (g_lane[0].done && g_lane[1].done && g_lane[2].done) break;
        end
        chk("all lanes finished", 256'({g_lane[2].done, g_lane[1].done, g_lane[0].done}), 256'(7));
        chk("handshake timeouts", 256'({g_lane[2].to, g_lane[1].to, g_lane[0].to}), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msk_aes_mc_serial.md
# msk_aes_mc_serial

Masked, column-serial MixColumns engine with a selectable forward or inverse mode. It transforms a full d-share 128-bit AES state over 4/C cycles, where C is the number of columns processed per cycle. The datapath is sharewise-linear and needs no randomness. It sits between the masked ShiftRows/AddRoundKey path and the state register, with valid/ready handshakes on both sides.

## Interface
- `d`, 2: number of shares (≥1).
- `C`, 1: columns per cycle. Legal values are 1, 2, 4; any other value raises an elaboration `$error`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input state valid.
- `in_ready` out 1: block can accept.
- `in_inverse` in 1: 0 selects MixColumns, 1 selects InvMixColumns. Sampled on accept.
- `in_data` in 128·d: masked state. Byte b occupies `[8·d·b +: 8·d]`. Within a byte, bit j of share i is at `d·j+i`.
- `in_bypass` in 1: present only with `SMAESH_MC_BYPASS_EN`. Sampled on accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out 128·d: result, same layout as `in_data`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`. `in_ready` is combinational in `out_ready`.
- Accept occurs when `in_valid & in_ready`:
  - Load `in_data` into the state buffer.
  - Latch the mode bit.
  - Clear the counter `cnt` (width clog2(4/C), minimum 1 bit).
  - Go to BUSY.
- BUSY, per cycle:
  - The C lowest columns of the buffer pass through C column units in the latched mode, every share independently.
  - The buffer rotates right by 32·d·C bits, and the transformed columns enter at the top.
  - `cnt` increments.
  - When `cnt == 4/C-1`, go to DONE. After the last cycle, every column is back in its original position.
- Column k is bytes 4k..4k+3, with byte 4k as row 0.
  - Forward matrix rows: {2,3,1,1}, rotated per row.
  - Inverse matrix rows: {e,b,d,9}, rotated per row.
  - Arithmetic is GF(2^8) mod x^8+x^4+x^3+x+1, applied per share.
- DONE:
  - `out_valid=1` and `out_data` equals the buffer.
  - The buffer holds while `out_ready=0`.
  - On `out_ready` with no new accept, go to IDLE.
  - On `out_ready` with a simultaneous accept, go straight to BUSY with the new data, giving back-to-back operation.
- `in_valid` is ignored during BUSY, since `in_ready=0`.
- Reset: asserting `rst_n` low at any time, including mid-BUSY, forces:
  - state to IDLE
  - `cnt`, buffer and mode to 0
  - `out_valid` to 0, `out_data` to 0, `in_ready` to 1
- Reset is released synchronously by design: `rst_n` deassertion is synchronised upstream.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`.
- Latency: accept at edge t, then `out_valid` is high from edge t+4/C. That is 4, 2 or 1 cycles for C=1, 2, 4.
- Throughput is one state per 4/C cycles under back-to-back traffic.
- No combinational path from `in_data` to `out_data`.
- The only combinational in→out path is `out_ready`→`in_ready`.

## Configuration
- `SMAESH_MC_BYPASS_EN` defined:
  - The `in_bypass` port exists and is latched on accept.
  - When the latched bypass is 1, BUSY rotates only: the column units are skipped and the output equals the input. This serves the AES final round.
  - Latency is unchanged.
- `SMAESH_MC_BYPASS_EN` undefined: no port, no bypass mux, and the transform always applies.

## Structure
- Package `smaesh_mc_pkg` holds:
  - the FSM state enum
  - constant `COL_W = 32`
  - the `xtime` function
  - forward and inverse coefficient constants
- Sub-module `msk_aes_mc_col_dual` is one unshared 32-bit column with a `inverse` select, purely combinational. It is instantiated d·C times, once per share per column slot.

## Test plan
- d=2, C=1, forward. Column 0 = db 13 53 45, others = f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6. Share0 is random r; share1 = x⊕r. Required: after 4 cycles, the share XOR gives 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6, and share0 equals MC(r).
- Inverse mode with the outputs above as input, for C=2 and C=4. Required: the original columns are recovered, with `out_valid` at t+2 and t+1 respectively.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid`. Required: `out_data` stable and `in_ready=0`. Then assert `out_ready` with `in_valid` in the same cycle. Required: the new state is accepted and the next result arrives 4/C cycles later.
- Pull `rst_n` low at BUSY `cnt=1` (C=1). Required: immediately `out_valid=0`, `in_ready=1`, buffer 0, with no spurious output after release.
- With `SMAESH_MC_BYPASS_EN`, forward, bypass=1, input d4 d4 d4 d5. Required: output d4 d4 d4 d5. With bypass=0, required: d5 d5 d7 d6.
- Elaboration with C=3. Required: `$error`.
